// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC, issues one instruction fetch at a time,
// holds the fetched word for decode and computes the next PC when it retires.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        branch,
    input  logic        zero_flag,
    input  logic [31:0] branch_imm,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    output logic        halted,
    output logic        misalign_trap,
    output logic [31:0] pc_out,
    output logic [31:0] instret
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        S_RESET,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   next_pc_c;
    logic              next_misaligned_c;

    // Next-PC selection for the held instruction; jump outranks a taken branch.
    always_comb begin
        next_pc_c = instr_pc + XLEN'(4);
        if (jump) begin
            next_pc_c = jump_target;
        end else if (branch && zero_flag) begin
            next_pc_c = instr_pc + branch_imm;
        end
        next_misaligned_c = (next_pc_c[1:0] != 2'b00);
    end

    assign imem_req_addr = pc_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_RESET;
            pc_out         <= RESET_VECTOR;
            instr_out      <= '0;
            instr_pc       <= '0;
            instret        <= '0;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            halted         <= 1'b0;
            misalign_trap  <= 1'b0;
        end else begin
            misalign_trap <= 1'b0;
            case (state)
                S_RESET: begin
                    state          <= S_REQ;
                    imem_req_valid <= 1'b1;
                end
                S_REQ: begin
                    if (imem_req_ready) begin
                        state          <= S_WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state       <= S_HOLD;
                        instr_out   <= imem_rsp_data;
                        instr_pc    <= pc_out;
                        instr_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Retire: redirect, count, then either refetch or park.
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        instret     <= instret + XLEN'(1);
                        if (next_misaligned_c) begin
                            pc_out        <= TRAP_VECTOR;
                            misalign_trap <= 1'b1;
                        end else begin
                            pc_out <= next_pc_c;
                        end
                        if (halt_req) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else begin
                            state          <= S_REQ;
                            imem_req_valid <= 1'b1;
                        end
                    end
                end
                S_HALTED: begin
                    if (!halt_req) begin
                        state          <= S_REQ;
                        halted         <= 1'b0;
                        imem_req_valid <= 1'b1;
                    end
                end
                default: begin
                    state          <= S_RESET;
                    imem_req_valid <= 1'b0;
                    instr_valid    <= 1'b0;
                    halted         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: scoreboard of fetched words plus a
// bench-side next-PC model driving address expectations.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        branch;
    logic        zero_flag;
    logic [31:0] branch_imm;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt_req;
    logic        halted;
    logic        misalign_trap;
    logic [31:0] pc_out;
    logic [31:0] instret;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_pc;
    logic [31:0] model_instret;

    pc_fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .branch         (branch),
        .zero_flag      (zero_flag),
        .branch_imm     (branch_imm),
        .jump           (jump),
        .jump_target    (jump_target),
        .halt_req       (halt_req),
        .halted         (halted),
        .misalign_trap  (misalign_trap),
        .pc_out         (pc_out),
        .instret        (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic br, input logic zf,
                                               input logic [31:0] imm, input logic j, input logic [31:0] tgt);
        logic [31:0] n;
        if (j)             n = tgt;
        else if (br && zf) n = pc + imm;
        else               n = pc + 32'd4;
        return (n[1:0] != 2'b00) ? 32'h0000_0100 : n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int rdy_stall, input int rsp_delay, input logic [31:0] data,
                            output logic [31:0] addr, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) ok = 1'b0;
        addr = imem_req_addr;
        repeat (rdy_stall) tick();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        repeat (rsp_delay) tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
    endtask

    task automatic fetch_sb(output logic [31:0] addr, output bit ok, output exp_t e);
        exp_t x;
        x.pc   = model_pc;
        x.data = $urandom;
        sb_q.push_back(x);
        do_fetch(0, 0, x.data, addr, ok);
        e = sb_q.pop_front();
    endtask

    task automatic do_retire(input logic br, input logic zf, input logic [31:0] imm,
                             input logic j, input logic [31:0] tgt, input logic halt);
        branch      = br;
        zero_flag   = zf;
        branch_imm  = imm;
        jump        = j;
        jump_target = tgt;
        halt_req    = halt;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        branch      = 1'b0;
        zero_flag   = 1'b0;
        branch_imm  = '0;
        jump        = 1'b0;
        jump_target = '0;
        model_pc      = model_next(model_pc, br, zf, imm, j, tgt);
        model_instret = model_instret + 32'd1;
    endtask

    task automatic test_reset();
        logic [31:0] a;
        bit          ok;
        exp_t        e;
        int          n = 0;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (pc_out !== 32'h0 || instret !== 32'h0 || instr_out !== 32'h0 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: pc=%h instret=%h instr=%h ipc=%h, want all 0", pc_out, instret, instr_out, instr_pc);
        end
        checks++;
        if ({imem_req_valid, instr_valid, halted, misalign_trap} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: req/ival/halted/trap=%b want 0000",
                     {imem_req_valid, instr_valid, halted, misalign_trap});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: imem_req_valid=%b want 0", imem_req_valid);
        end
        while (imem_req_valid !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        checks++;
        if (imem_req_valid !== 1'b1 || n > 2 || imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: valid=%b edges=%0d addr=%h want 1, <=2, 0", imem_req_valid, n, imem_req_addr);
        end
        model_pc      = 32'h0;
        model_instret = 32'h0;
        for (int i = 0; i < 3; i++) begin
            fetch_sb(a, ok, e);
            checks++;
            if (!ok || a !== model_pc) begin
                errors++;
                $display("FAIL seq_addr[%0d]: got %h want %h ok=%0d", i, a, model_pc, ok);
            end
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr_out !== e.data) begin
                errors++;
                $display("FAIL seq_instr[%0d]: v=%b pc=%h data=%h want 1 %h %h", i, instr_valid, instr_pc, instr_out, e.pc, e.data);
            end
            do_retire(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        end
        checks++;
        if (instret !== 32'd3) begin
            errors++;
            $display("FAIL seq_instret: got %0d want 3", instret);
        end
    endtask

    task automatic test_redirect();
        bit          r_br [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bit          r_zf [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        bit          r_j  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] r_imm[6] = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h40, 32'h0, 32'h0};
        logic [31:0] r_tgt[6] = '{32'h20, 32'h0, 32'h0, 32'h400, 32'hFFFF_FFFC, 32'h0};
        logic [31:0] want [6] = '{32'hC, 32'h20, 32'h18, 32'h1C, 32'h400, 32'hFFFF_FFFC};
        logic [31:0] a;
        bit          ok;
        exp_t        e;
        for (int k = 0; k < 6; k++) begin
            fetch_sb(a, ok, e);
            checks++;
            if (!ok || a !== want[k]) begin
                errors++;
                $display("FAIL redirect_addr[%0d]: got %h want %h ok=%0d", k, a, want[k], ok);
            end
            checks++;
            if (instr_pc !== e.pc || instr_out !== e.data) begin
                errors++;
                $display("FAIL redirect_instr[%0d]: pc=%h data=%h want %h %h", k, instr_pc, instr_out, e.pc, e.data);
            end
            do_retire(r_br[k], r_zf[k], r_imm[k], r_j[k], r_tgt[k], 1'b0);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] a;
        bit          ok;
        exp_t        e;
        fetch_sb(a, ok, e);
        checks++;
        if (!ok || a !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got %h want 00000000", a);
        end
        checks++;
        if (misalign_trap !== 1'b0) begin
            errors++;
            $display("FAIL trap_idle: misalign_trap=%b want 0", misalign_trap);
        end
        do_retire(1'b0, 1'b0, 32'h0, 1'b1, 32'h402, 1'b0);
        checks++;
        if (pc_out !== 32'h100 || misalign_trap !== 1'b1) begin
            errors++;
            $display("FAIL trap_pulse: pc=%h trap=%b want 00000100 1", pc_out, misalign_trap);
        end
        tick();
        checks++;
        if (misalign_trap !== 1'b0) begin
            errors++;
            $display("FAIL trap_width: misalign_trap=%b want 0", misalign_trap);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a0;
        exp_t        x;
        exp_t        e;
        int          n = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        a0 = imem_req_addr;
        checks++;
        if (imem_req_valid !== 1'b1 || a0 !== model_pc) begin
            errors++;
            $display("FAIL trap_fetch_addr: valid=%b addr=%h want 1 %h", imem_req_valid, a0, model_pc);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL req_stall[%0d]: valid=%b addr=%h ival=%b want 1 %h 0", i, imem_req_valid, imem_req_addr, instr_valid, a0);
            end
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL rsp_wait[%0d]: ival=%b req=%b want 0 0", i, instr_valid, imem_req_valid);
            end
        end
        x.pc   = model_pc;
        x.data = 32'h0123_4567;
        sb_q.push_back(x);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = x.data;
        tick();
        imem_rsp_data  = 32'hFEED_F00D;
        jump           = 1'b1;
        jump_target    = 32'h888;
        e = sb_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== e.data || instr_pc !== e.pc || instret !== model_instret) begin
                errors++;
                $display("FAIL hold_stall[%0d]: v=%b data=%h pc=%h ir=%0d want 1 %h %h %0d",
                         i, instr_valid, instr_out, instr_pc, instret, e.data, e.pc, model_instret);
            end
        end
        imem_rsp_valid = 1'b0;
        do_retire(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (instret !== model_instret || pc_out !== model_pc) begin
            errors++;
            $display("FAIL stall_retire: instret=%0d pc=%h want %0d %h", instret, pc_out, model_instret, model_pc);
        end
    endtask

    task automatic test_halt();
        logic [31:0] a;
        bit          ok;
        exp_t        e;
        fetch_sb(a, ok, e);
        checks++;
        if (!ok || a !== model_pc || instr_out !== e.data) begin
            errors++;
            $display("FAIL halt_fetch: addr=%h data=%h want %h %h", a, instr_out, model_pc, e.data);
        end
        do_retire(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (halted !== 1'b1 || imem_req_valid !== 1'b0 || pc_out !== 32'h80) begin
                errors++;
                $display("FAIL halted[%0d]: halted=%b req=%b pc=%h want 1 0 00000080", i, halted, imem_req_valid, pc_out);
            end
            tick();
        end
        imem_req_ready = 1'b0;
        halt_req       = 1'b0;
        tick();
        checks++;
        if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80 || instret !== model_instret) begin
            errors++;
            $display("FAIL resume: halted=%b req=%b addr=%h ir=%0d want 0 1 00000080 %0d",
                     halted, imem_req_valid, imem_req_addr, instret, model_instret);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] a;
        bit          ok;
        exp_t        e;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc_out !== 32'h0 || instret !== 32'h0 || instr_out !== 32'h0 || instr_pc !== 32'h0 ||
            {imem_req_valid, instr_valid, halted, misalign_trap} !== 4'b0000) begin
            errors++;
            $display("FAIL midop_reset: pc=%h ir=%h instr=%h ipc=%h flags=%b want all 0",
                     pc_out, instret, instr_out, instr_pc, {imem_req_valid, instr_valid, halted, misalign_trap});
        end
        @(negedge clk);
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        checks++;
        if (instr_valid !== 1'b0 || instr_out !== 32'h0) begin
            errors++;
            $display("FAIL late_rsp: ival=%b instr=%h want 0 00000000", instr_valid, instr_out);
        end
        model_pc      = 32'h0;
        model_instret = 32'h0;
        fetch_sb(a, ok, e);
        checks++;
        if (!ok || a !== 32'h0 || instr_out !== e.data || instr_pc !== e.pc) begin
            errors++;
            $display("FAIL restart: addr=%h data=%h pc=%h want 00000000 %h %h", a, instr_out, instr_pc, e.data, e.pc);
        end
        do_retire(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (instret !== model_instret || pc_out !== model_pc) begin
            errors++;
            $display("FAIL restart_retire: ir=%0d pc=%h want %0d %h", instret, pc_out, model_instret, model_pc);
        end
    endtask

    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        branch         = 1'b0;
        zero_flag      = 1'b0;
        branch_imm     = '0;
        jump           = 1'b0;
        jump_target    = '0;
        halt_req       = 1'b0;
        model_pc       = '0;
        model_instret  = '0;
        test_reset();
        test_redirect();
        test_misalign();
        test_stall();
        test_halt();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
